// File: rtl/ula_operand_loader.sv
// Operand loader for the ULA: collects one or two operand bytes from a shared bus,
// then pulses grab (execute) and done. Unary opcode 3'b111 skips the second operand.
module ula_operand_loader #(
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_bus,
    input  logic       bus_valid,
    input  logic       start,
    input  logic [2:0] opcode,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [2:0] ula_op,
    output logic       grab,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_A = 3'd1,
        S_WAIT_B = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] OP_UNARY = 3'b111;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_op_a;
    logic [7:0] r_op_b;
    logic [2:0] r_ula_op;
    logic       r_grab;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    // Sequencer: grab/busy/done are registered alongside the state they decode
    always_ff @(negedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_op_a   <= 8'd0;
            r_op_b   <= 8'd0;
            r_ula_op <= 3'd0;
            r_grab   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_grab <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ula_op <= opcode;
                        r_err    <= 1'b0;
                        r_cnt    <= 8'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_WAIT_A;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_A: begin
                    if (bus_valid) begin
                        r_op_a <= data_bus;
                        r_cnt  <= 8'd0;
                        if (r_ula_op == OP_UNARY) begin
                            r_op_b  <= 8'd0;
                            r_grab  <= 1'b1;
                            r_state <= S_EXEC;
                        end else begin
                            r_state <= S_WAIT_B;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WAIT_B: begin
                    // A valid byte wins over an expiring timeout on the same edge
                    if (bus_valid) begin
                        r_op_b  <= data_bus;
                        r_cnt   <= 8'd0;
                        r_grab  <= 1'b1;
                        r_state <= S_EXEC;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign op_a   = r_op_a;
    assign op_b   = r_op_b;
    assign ula_op = r_ula_op;
    assign grab   = r_grab;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_ula_operand_loader.sv
// Directed bench for ula_operand_loader; inputs change just after each falling edge,
// outputs are sampled 1 time unit after that edge.
module tb_ula_operand_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_bus;
    logic       bus_valid;
    logic       start;
    logic [2:0] opcode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] ula_op;
    logic       grab;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    ula_operand_loader #(.TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .data_bus(data_bus), .bus_valid(bus_valid),
        .start(start), .opcode(opcode), .op_a(op_a), .op_b(op_b), .ula_op(ula_op),
        .grab(grab), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bus_valid = 1'b0; data_bus = 8'h00; opcode = 3'd0;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({op_a, op_b, ula_op} !== 19'd0) begin
            n_bad++; $display("FAIL reset_ops got %h/%h/%h want 00/00/0", op_a, op_b, ula_op);
        end
        n_cmp++;
        if ({grab, busy, done, err} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got %b want 0000", {grab, busy, done, err});
        end
    endtask

    task automatic test_binary();
        start = 1'b1; opcode = 3'b001;
        tick();
        start = 1'b0; bus_valid = 1'b1; data_bus = 8'h12;
        n_cmp++;
        if ({busy, grab, ula_op} !== 5'b10_001) begin
            n_bad++; $display("FAIL bin_start got busy=%b grab=%b op=%h want 1 0 1", busy, grab, ula_op);
        end
        tick();
        data_bus = 8'h34;
        n_cmp++;
        if (op_a !== 8'h12 || grab !== 1'b0) begin
            n_bad++; $display("FAIL bin_a got op_a=%h grab=%b want 12 0", op_a, grab);
        end
        tick();
        bus_valid = 1'b0; data_bus = 8'hFF;
        n_cmp++;
        if (op_b !== 8'h34 || grab !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL bin_exec got op_b=%h grab=%b done=%b want 34 1 0", op_b, grab, done);
        end
        tick();
        n_cmp++;
        if (grab !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL bin_done got grab=%b done=%b busy=%b want 0 1 1", grab, done, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || op_a !== 8'h12 || op_b !== 8'h34) begin
            n_bad++; $display("FAIL bin_idle got done=%b busy=%b a=%h b=%h want 0 0 12 34", done, busy, op_a, op_b);
        end
    endtask

    task automatic test_unary();
        start = 1'b1; opcode = 3'b111;
        tick();
        start = 1'b0; bus_valid = 1'b1; data_bus = 8'hA5;
        n_cmp++;
        if (grab !== 1'b0 || ula_op !== 3'b111) begin
            n_bad++; $display("FAIL un_start got grab=%b op=%h want 0 7", grab, ula_op);
        end
        tick();
        bus_valid = 1'b0;
        n_cmp++;
        if (op_a !== 8'hA5 || op_b !== 8'h00 || grab !== 1'b1) begin
            n_bad++; $display("FAIL un_exec got a=%h b=%h grab=%b want A5 00 1", op_a, op_b, grab);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL un_done got %b want 1", done);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL un_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_timeout();
        int seen_pulse = 0;
        start = 1'b1; opcode = 3'b010; bus_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (grab || done) seen_pulse++;
        end
        n_cmp++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL to_14 got busy=%b err=%b want 1 0", busy, err);
        end
        tick();
        if (grab || done) seen_pulse++;
        n_cmp++;
        if (busy !== 1'b0 || err !== 1'b1 || seen_pulse != 0) begin
            n_bad++; $display("FAIL to_15 got busy=%b err=%b pulses=%0d want 0 1 0", busy, err, seen_pulse);
        end
        tick();
        n_cmp++;
        if (err !== 1'b1 || op_a !== 8'hA5 || ula_op !== 3'b010) begin
            n_bad++; $display("FAIL to_hold got err=%b a=%h op=%h want 1 A5 2", err, op_a, ula_op);
        end
        start = 1'b1; opcode = 3'b011;
        tick();
        start = 1'b0;
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL to_clear got err=%b busy=%b want 0 1", err, busy);
        end
    endtask

    // Continues the operation started at the end of test_timeout (sitting in WAIT_A)
    task automatic test_boundary();
        bus_valid = 1'b1; data_bus = 8'h77;
        tick();
        bus_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        n_cmp++;
        if (busy !== 1'b1 || grab !== 1'b0) begin
            n_bad++; $display("FAIL bd_wait got busy=%b grab=%b want 1 0", busy, grab);
        end
        bus_valid = 1'b1; data_bus = 8'h88;
        tick();
        bus_valid = 1'b0;
        n_cmp++;
        if (op_a !== 8'h77 || op_b !== 8'h88 || err !== 1'b0 || grab !== 1'b1) begin
            n_bad++; $display("FAIL bd_cap got a=%h b=%h err=%b grab=%b want 77 88 0 1", op_a, op_b, err, grab);
        end
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL bd_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen_pulse = 0;
        start = 1'b1; opcode = 3'b001;
        tick();
        opcode = 3'b010;
        tick();
        n_cmp++;
        if (ula_op !== 3'b001 || busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_ignore got op=%h busy=%b want 1 1", ula_op, busy);
        end
        start = 1'b0; bus_valid = 1'b1; data_bus = 8'h55;
        tick();
        bus_valid = 1'b0;
        n_cmp++;
        if (op_a !== 8'h55) begin
            n_bad++; $display("FAIL mid_a got %h want 55", op_a);
        end
        reset = 1'b1; bus_valid = 1'b1; data_bus = 8'h66;
        tick();
        reset = 1'b0; bus_valid = 1'b0;
        n_cmp++;
        if (op_a !== 8'h00 || op_b !== 8'h00 || busy !== 1'b0 || grab !== 1'b0 || ula_op !== 3'd0) begin
            n_bad++; $display("FAIL mid_rst got a=%h b=%h busy=%b grab=%b want 00 00 0 0", op_a, op_b, busy, grab);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (grab || done || busy) seen_pulse++;
        end
        n_cmp++;
        if (seen_pulse != 0) begin
            n_bad++; $display("FAIL mid_quiet got %0d active cycles want 0", seen_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_unary();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
